// File: rtl/updown_sweep_ctrl.sv
// ============================================================================
//  Module   : updown_sweep_ctrl
//  Brief    : Triangular sweep sequencer for an 8-bit up/down counter.
//             Generates direction and step strobes between programmable
//             low/high limits with step prescaler, end-point dwell, cycle
//             count, start/abort control and done/error status.
//             Optional macro SWEEP_PAUSE_EN adds an in_Pause freeze input.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DIV_W   = 8,
  parameter int DWELL_W = 8,
  parameter int CYC_W   = 4
) (
  input  logic               in_Clk,
  input  logic               in_Reset,
  input  logic               in_Start,
  input  logic               in_Abort,
  input  logic [WIDTH-1:0]   in_LowLimit,
  input  logic [WIDTH-1:0]   in_HighLimit,
  input  logic [DIV_W-1:0]   in_StepDiv,
  input  logic [DWELL_W-1:0] in_Dwell,
  input  logic [CYC_W-1:0]   in_Cycles,
`ifdef SWEEP_PAUSE_EN
  input  logic               in_Pause,
`endif
  output logic [WIDTH-1:0]   out_Count,
  output logic               out_UporDown,
  output logic               out_Step,
  output logic               out_Busy,
  output logic               out_Done,
  output logic               out_Err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UP       = 3'd1,
    S_DWELL_HI = 3'd2,
    S_DOWN     = 3'd3,
    S_DWELL_LO = 3'd4
  } state_t;

  state_t state, state_next;

  // Configuration captured at start; inputs are ignored while busy
  logic [WIDTH-1:0]   low_cfg, high_cfg;
  logic [DIV_W-1:0]   div_cfg;
  logic [DWELL_W-1:0] dwell_cfg;
  logic [CYC_W-1:0]   cycles_cfg;

  logic [DIV_W-1:0]   presc;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [WIDTH-1:0]   count;
  logic               updown;
  logic               done;
  logic               err;

  logic               busy;
  logic               pause;
  logic               tick;
  logic               run_state;
  logic               dwell_state;
  logic               dwell_last;
  logic [WIDTH-1:0]   count_inc;
  logic [WIDTH-1:0]   count_dec;
  logic [CYC_W-1:0]   cyc_new;
  logic               step;
  logic               load_cfg;
  logic               err_set;
  logic               done_set;
  logic               cyc_inc;

  assign busy = (state != S_IDLE);

`ifdef SWEEP_PAUSE_EN
  // Pause only matters while a sweep is running
  assign pause = in_Pause & busy;
`else
  assign pause = 1'b0;
`endif

  assign tick        = (presc == div_cfg);
  assign run_state   = (state == S_UP) || (state == S_DOWN);
  assign dwell_state = (state == S_DWELL_HI) || (state == S_DWELL_LO);
  assign dwell_last  = (dwell_cnt == (dwell_cfg - DWELL_W'(1)));
  assign count_inc   = count + WIDTH'(1);
  assign count_dec   = count - WIDTH'(1);
  assign cyc_new     = cyc_cnt + CYC_W'(1);

  // State register
  always_ff @(posedge in_Clk) begin
    if (in_Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and step/status decode; abort beats pause beats normal flow
  always_comb begin
    state_next = state;
    step       = 1'b0;
    load_cfg   = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    cyc_inc    = 1'b0;
    if (busy && in_Abort) begin
      state_next = S_IDLE;
    end else if (pause) begin
      state_next = state;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_Start && !in_Abort) begin
            if (in_LowLimit < in_HighLimit) begin
              load_cfg   = 1'b1;
              state_next = S_UP;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        S_UP: begin
          if (tick) begin
            step = 1'b1;
            if (count_inc == high_cfg) begin
              if (dwell_cfg == '0) state_next = S_DOWN;
              else                 state_next = S_DWELL_HI;
            end
          end
        end
        S_DWELL_HI: begin
          if (dwell_last) state_next = S_DOWN;
        end
        S_DOWN: begin
          if (tick) begin
            step = 1'b1;
            if (count_dec == low_cfg) begin
              cyc_inc = 1'b1;
              if ((cycles_cfg != '0) && (cyc_new == cycles_cfg)) begin
                state_next = S_IDLE;
                done_set   = 1'b1;
              end else if (dwell_cfg == '0) begin
                state_next = S_UP;
              end else begin
                state_next = S_DWELL_LO;
              end
            end
          end
        end
        S_DWELL_LO: begin
          if (dwell_last) state_next = S_UP;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: config capture, count, counters, direction and status pulses
  always_ff @(posedge in_Clk) begin
    if (in_Reset) begin
      low_cfg    <= '0;
      high_cfg   <= '0;
      div_cfg    <= '0;
      dwell_cfg  <= '0;
      cycles_cfg <= '0;
      presc      <= '0;
      dwell_cnt  <= '0;
      cyc_cnt    <= '0;
      count      <= '0;
      updown     <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= done_set;
      err  <= err_set;

      if (load_cfg) begin
        low_cfg    <= in_LowLimit;
        high_cfg   <= in_HighLimit;
        div_cfg    <= in_StepDiv;
        dwell_cfg  <= in_Dwell;
        cycles_cfg <= in_Cycles;
        count      <= in_LowLimit;
        cyc_cnt    <= '0;
      end else begin
        if (step && (state == S_UP))   count <= count_inc;
        if (step && (state == S_DOWN)) count <= count_dec;
        if (cyc_inc)                   cyc_cnt <= cyc_new;
      end

      // Direction follows the run state being entered; held in IDLE
      if (state_next == S_UP)        updown <= 1'b1;
      else if (state_next == S_DOWN) updown <= 1'b0;

      // Prescaler restarts on every state change so each run starts in phase
      if (state_next != state)       presc <= '0;
      else if (run_state && !pause)  presc <= tick ? '0 : presc + DIV_W'(1);

      if (state_next != state)        dwell_cnt <= '0;
      else if (dwell_state && !pause) dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

  assign out_Count    = count;
  assign out_UporDown = updown;
  assign out_Step     = step;
  assign out_Busy     = busy;
  assign out_Done     = done;
  assign out_Err      = err;

endmodule

`default_nettype wire
